// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module   : alu_mul_seq (with helper alu)
//  Brief    : 16x16->16 shift-and-add multiplier sequenced through one Hack ALU.
//             Optional macro ALU_MUL_SKIP_EN skips leading zero multiplier bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic        zr,
   output logic        ng,
   output logic [15:0] out
);
   logic [15:0] w_x, w_y, w_f;

   always_comb begin
      w_x = zx ? 16'h0000 : x;
      w_x = nx ? ~w_x : w_x;
      w_y = zy ? 16'h0000 : y;
      w_y = ny ? ~w_y : w_y;
      w_f = f ? (w_x + w_y) : (w_x & w_y);
      out = no ? ~w_f : w_f;
      zr  = (out == 16'h0000);
      ng  = out[15];
   end
endmodule

module alu_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             zr,
   output logic             ng
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DBL  = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b, r_acc, r_product;
   logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_acc_nxt, w_product_nxt;
   logic [3:0]       r_cnt, w_cnt_nxt;
   logic             r_busy, r_done, r_zr, r_ng;
   logic             w_busy_nxt, w_done_nxt, w_zr_nxt, w_ng_nxt;

   logic             w_alu_add, w_alu_zr, w_alu_ng, w_bit;
   logic [15:0]      w_alu_y, w_alu_out;

`ifdef ALU_MUL_SKIP_EN
   // Leading-zero count; returns 16 for an all-zero operand.
   function automatic logic [4:0] f_lz(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd16;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) n = 5'(15 - i);
      end
      return n;
   endfunction

   logic [4:0] w_lz;
   assign w_lz = f_lz(b);
`endif

   assign w_alu_add = (r_state == S_DBL) || (r_state == S_ADD);
   assign w_alu_y   = (r_state == S_DBL) ? r_acc : r_a;
   assign w_bit     = r_b[4'd15 - r_cnt];

   alu u_alu (
      .x   (r_acc),
      .y   (w_alu_y),
      .zx  (~w_alu_add),
      .nx  (1'b0),
      .zy  (~w_alu_add),
      .ny  (1'b0),
      .f   (1'b1),
      .no  (1'b0),
      .zr  (w_alu_zr),
      .ng  (w_alu_ng),
      .out (w_alu_out)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_a_nxt       = r_a;
      w_b_nxt       = r_b;
      w_acc_nxt     = r_acc;
      w_cnt_nxt     = r_cnt;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_product_nxt = r_product;
      w_zr_nxt      = r_zr;
      w_ng_nxt      = r_ng;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_a_nxt     = a;
               w_b_nxt     = b;
               w_acc_nxt   = '0;
               w_cnt_nxt   = 4'd0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_DBL;
`ifdef ALU_MUL_SKIP_EN
               w_cnt_nxt = w_lz[3:0];
               if (w_lz[4]) begin
                  w_busy_nxt    = 1'b0;
                  w_done_nxt    = 1'b1;
                  w_product_nxt = '0;
                  w_zr_nxt      = 1'b1;
                  w_ng_nxt      = 1'b0;
                  w_state_nxt   = S_DONE;
               end
`endif
            end
         end
         S_DBL, S_ADD: begin
            w_acc_nxt = w_alu_out;
            if ((r_state == S_DBL) && w_bit) begin
               w_state_nxt = S_ADD;
            end else if (r_cnt == 4'd15) begin
               // Capture the ALU result directly: acc is updated on this same edge.
               w_state_nxt   = S_DONE;
               w_product_nxt = w_alu_out;
               w_zr_nxt      = w_alu_zr;
               w_ng_nxt      = w_alu_ng;
               w_done_nxt    = 1'b1;
               w_busy_nxt    = 1'b0;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
               w_state_nxt = S_DBL;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_cnt     <= 4'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_product <= '0;
         r_zr      <= 1'b1;
         r_ng      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_a       <= w_a_nxt;
         r_b       <= w_b_nxt;
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_product <= w_product_nxt;
         r_zr      <= w_zr_nxt;
         r_ng      <= w_ng_nxt;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;
   assign zr      = r_zr;
   assign ng      = r_ng;

endmodule

`default_nettype wire
